// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of core stores draining to data memory, with optional
// store-to-load forwarding built when the STORE_BUFFER_FWD_EN macro is defined.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic [AW-1:0] DataAdr,
    input  logic [DW-1:0] WriteData,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [AW-1:0] ld_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;

    // Status flags decode straight from the registered occupancy.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign mem_we   = ~empty;
    assign overflow = ovf_q;

    // A pop frees a slot in the same cycle, so a full buffer can still accept.
    assign pop  = mem_we & mem_ready;
    assign push = MemWrite & (~full | pop);

    assign mem_addr  = mem_we ? mem_q[head_q].addr : '0;
    assign mem_wdata = mem_we ? mem_q[head_q].data : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (MemWrite && !push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Payload storage needs no reset; outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{addr: DataAdr, data: WriteData};
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    // Scan oldest to youngest so the last (youngest) match overrides earlier ones.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_q[idx].addr == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_q[idx].data;
            end
        end
    end
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^ld_addr;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, AW=DW=32).
module tb_store_buffer;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          MemWrite;
    logic [AW-1:0] DataAdr;
    logic [DW-1:0] WriteData;
    logic          full, empty, overflow, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [AW-1:0] ld_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    int n_cmp = 0;
    int n_err = 0;

    store_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .full(full), .empty(empty), .overflow(overflow),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        MemWrite = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        mem_ready = 1'b0; ld_addr = '0;
        tick();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_cmp++; if (mem_addr !== 32'd0) begin n_err++; $display("FAIL reset_mem_addr got=%0d exp=0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'd0) begin n_err++; $display("FAIL reset_mem_wdata got=%0d exp=0", mem_wdata); end
        n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL reset_fwd_hit got=%b exp=0", fwd_hit); end
        n_cmp++; if (fwd_data !== 32'd0) begin n_err++; $display("FAIL reset_fwd_data got=%0d exp=0", fwd_data); end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_single();
        mem_ready = 1'b1;
        push(32'd100, 32'd25);
        n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL single_we got=%b exp=1", mem_we); end
        n_cmp++; if (mem_addr !== 32'd100) begin n_err++; $display("FAIL single_addr got=%0d exp=100", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'd25) begin n_err++; $display("FAIL single_data got=%0d exp=25", mem_wdata); end
        tick();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full_overflow();
        logic [AW-1:0] ea [4];
        logic [DW-1:0] ed [4];
        ea = '{32'd96, 32'd100, 32'd104, 32'd108};
        ed = '{32'd7, 32'd25, 32'd3, 32'd9};
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL fill_full_early i=%0d got=%b exp=0", i, full); end
            push(ea[i], ed[i]);
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_ovf got=%b exp=0", overflow); end
        push(32'd112, 32'd1);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL drop_ovf got=%b exp=1", overflow); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL drop_full got=%b exp=1", full); end
        n_cmp++; if (mem_addr !== 32'd96) begin n_err++; $display("FAIL drop_head got=%0d exp=96", mem_addr); end
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL drain_we i=%0d got=%b exp=1", i, mem_we); end
            n_cmp++; if (mem_addr !== ea[i]) begin n_err++; $display("FAIL drain_addr i=%0d got=%0d exp=%0d", i, mem_addr, ea[i]); end
            n_cmp++; if (mem_wdata !== ed[i]) begin n_err++; $display("FAIL drain_data i=%0d got=%0d exp=%0d", i, mem_wdata, ed[i]); end
            tick();
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got=%b exp=1", empty); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_push_pop_full();
        logic [AW-1:0] ea [4];
        logic [DW-1:0] ed [4];
        ea = '{32'd100, 32'd104, 32'd108, 32'd112};
        ed = '{32'd25, 32'd3, 32'd9, 32'd1};
        apply_reset();
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_cleared got=%b exp=0", overflow); end
        push(32'd96, 32'd7);
        push(32'd100, 32'd25);
        push(32'd104, 32'd3);
        push(32'd108, 32'd9);
        mem_ready = 1'b1;
        push(32'd112, 32'd1);
        mem_ready = 1'b0;
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL pp_full got=%b exp=1", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL pp_ovf got=%b exp=0", overflow); end
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem_addr !== ea[i]) begin n_err++; $display("FAIL pp_addr i=%0d got=%0d exp=%0d", i, mem_addr, ea[i]); end
            n_cmp++; if (mem_wdata !== ed[i]) begin n_err++; $display("FAIL pp_data i=%0d got=%0d exp=%0d", i, mem_wdata, ed[i]); end
            tick();
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL pp_empty got=%b exp=1", empty); end
    endtask

    task automatic test_forward();
        apply_reset();
        push(32'd100, 32'd25);
        push(32'd100, 32'd40);
        ld_addr = 32'd100;
        #1;
        n_cmp++; if (fwd_hit !== FWD) begin n_err++; $display("FAIL fwd_hit100 got=%b exp=%b", fwd_hit, FWD); end
        n_cmp++; if (fwd_data !== (FWD ? 32'd40 : 32'd0)) begin n_err++; $display("FAIL fwd_data100 got=%0d exp=%0d", fwd_data, FWD ? 40 : 0); end
        ld_addr = 32'd104;
        #1;
        n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_hit104 got=%b exp=0", fwd_hit); end
        ld_addr = 32'd100;
        mem_ready = 1'b1;
        tick();
        n_cmp++; if (fwd_data !== (FWD ? 32'd40 : 32'd0)) begin n_err++; $display("FAIL fwd_after_pop got=%0d exp=%0d", fwd_data, FWD ? 40 : 0); end
        tick();
        n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_empty got=%b exp=0", fwd_hit); end
        ld_addr = '0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        push(32'd200, 32'd11);
        push(32'd204, 32'd12);
        push(32'd208, 32'd13);
        mem_ready = 1'b1;
        tick();
        n_cmp++; if (mem_addr !== 32'd204) begin n_err++; $display("FAIL ar_head got=%0d exp=204", mem_addr); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL ar_we got=%b exp=0", mem_we); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ar_empty got=%b exp=1", empty); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL ar_stale i=%0d got=%b exp=0", i, mem_we); end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            MemWrite  = 1'b1;
            DataAdr   = 32'h300 + 32'(4 * i);
            WriteData = 32'(50 + i);
            tick();
            n_cmp++; if (mem_addr !== 32'h300 + 32'(4 * i)) begin n_err++; $display("FAIL b2b_addr i=%0d got=%0h exp=%0h", i, mem_addr, 32'h300 + 32'(4 * i)); end
            n_cmp++; if (mem_wdata !== 32'(50 + i)) begin n_err++; $display("FAIL b2b_data i=%0d got=%0d exp=%0d", i, mem_wdata, 50 + i); end
        end
        MemWrite = 1'b0;
        tick();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty got=%b exp=1", empty); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got=%b exp=0", overflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_overflow();
        test_push_pop_full();
        test_forward();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
